// File: rtl/alu_scheduler.sv
// Round-robin scheduler that shares one combinational ALU between two requesters.
// Exactly one operation is in flight; the result returns on a valid/ready response channel.
module alu_scheduler #(
    parameter int W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [3:0]    req_opcode0,
    input  logic [3:0]    req_opcode1,
    input  logic [W-1:0]  req_a0,
    input  logic [W-1:0]  req_b0,
    input  logic [W-1:0]  req_a1,
    input  logic [W-1:0]  req_b1,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_opcode,
    input  logic [W-1:0]  alu_result,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [W-1:0]  rsp_result,
    output logic          rsp_zero,
    output logic          rsp_err,
    output logic          busy
);

    // state     | meaning
    // S_IDLE    | waiting for a request; grant and latch it
    // S_ISSUE   | drive the ALU inputs from the holding registers
    // S_CAPTURE | register the ALU result and status
    // S_RESP    | hold the response until rsp_ready
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_RESET = 4'b0001;

    state_t         state;
    logic           prio;
    logic           hold_id;
    logic [3:0]     hold_op;
    logic [W-1:0]   hold_a;
    logic [W-1:0]   hold_b;
    logic [1:0]     grant;
    logic           g;
    logic [W-1:0]   cap_result;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000,
            4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101: op_legal = 1'b1;
            default:                                     op_legal = 1'b0;
        endcase
    endfunction

    always_comb begin
        grant = 2'b00;
        g     = 1'b0;
        if (state == S_IDLE) begin
            if (req_valid == 2'b11) begin
                g        = prio;
                grant[prio] = 1'b1;
            end else if (req_valid[0]) begin
                g        = 1'b0;
                grant[0] = 1'b1;
            end else if (req_valid[1]) begin
                g        = 1'b1;
                grant[1] = 1'b1;
            end
        end
    end

    // NOP, RESET and illegal opcodes all report zero regardless of the ALU output
    always_comb begin
        cap_result = '0;
        if (op_legal(hold_op) && hold_op != OP_NOP && hold_op != OP_RESET)
            cap_result = alu_result;
    end

    assign req_ready = grant;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            prio       <= 1'b0;
            hold_id    <= 1'b0;
            hold_op    <= 4'b0000;
            hold_a     <= '0;
            hold_b     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= 4'b0000;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|grant) begin
                        hold_id <= g;
                        hold_op <= g ? req_opcode1 : req_opcode0;
                        hold_a  <= g ? req_a1 : req_a0;
                        hold_b  <= g ? req_b1 : req_b0;
                        prio    <= ~g;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    alu_a      <= hold_a;
                    alu_b      <= hold_b;
                    alu_opcode <= (op_legal(hold_op) && hold_op != OP_RESET) ? hold_op : 4'b0000;
                    state      <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    rsp_result <= cap_result;
                    rsp_zero   <= (cap_result == '0);
                    rsp_err    <= ~op_legal(hold_op);
                    rsp_id     <= hold_id;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a behavioural ALU closing the loop.
module tb_alu_scheduler;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [3:0]    req_opcode0, req_opcode1;
    logic [W-1:0]  req_a0, req_b0, req_a1, req_b1;
    logic [W-1:0]  alu_a, alu_b;
    logic [3:0]    alu_opcode;
    logic [W-1:0]  alu_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [W-1:0]  rsp_result;
    logic          rsp_zero;
    logic          rsp_err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    alu_scheduler #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode0(req_opcode0), .req_opcode1(req_opcode1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_opcode)
            4'b0100: alu_result = alu_a + alu_b;
            4'b0101: alu_result = alu_a - alu_b;
            4'b1000: alu_result = alu_a & alu_b;
            4'b1001: alu_result = alu_a | alu_b;
            4'b1010: alu_result = alu_a ^ alu_b;
            4'b1011: alu_result = ~(alu_a & alu_b);
            4'b1100: alu_result = ~(alu_a | alu_b);
            4'b1101: alu_result = ~alu_a;
            4'b0000: alu_result = 16'hDEAD;
            default: alu_result = 16'hBEEF;
        endcase
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input logic id, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        if (id) begin
            req_opcode1 = op; req_a1 = a; req_b1 = b;
        end else begin
            req_opcode0 = op; req_a0 = a; req_b0 = b;
        end
    endtask

    // Drives one request from idle and stops with the response pending; reports the issued opcode.
    task automatic run_op(input logic id, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output logic [3:0] seen_op);
        set_req(id, op, a, b);
        req_valid = id ? 2'b10 : 2'b01;
        rsp_ready = 1'b0;
        step();
        req_valid = 2'b00;
        step();
        seen_op = alu_opcode;
        step();
    endtask

    task automatic handshake;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        req_opcode0 = 4'b0100; req_opcode1 = 4'b0100;
        req_a0 = 16'h5555; req_b0 = 16'hAAAA; req_a1 = 16'h1111; req_b1 = 16'h2222;
        do_reset();
        checks++;
        if ({busy, req_ready, rsp_valid, rsp_id, rsp_zero, rsp_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b ready=%b valid=%b id=%b zero=%b err=%b expected all 0",
                     busy, req_ready, rsp_valid, rsp_id, rsp_zero, rsp_err);
        end
        checks++;
        if ({alu_a, alu_b, alu_opcode, rsp_result} !== 52'h0) begin
            errors++;
            $display("FAIL reset_data got a=%h b=%h op=%b res=%h expected 0", alu_a, alu_b, alu_opcode, rsp_result);
        end
    endtask

    task automatic test_single;
        do_reset();
        set_req(1'b0, 4'b0100, 16'h1234, 16'h0011);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL single_ready got %b expected 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        checks++;
        if (busy !== 1'b1 || req_ready !== 2'b00) begin
            errors++; $display("FAIL single_busy got busy=%b ready=%b expected 1/00", busy, req_ready);
        end
        step();
        checks++;
        if (alu_a !== 16'h1234 || alu_b !== 16'h0011 || alu_opcode !== 4'b0100 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_issue got a=%h b=%h op=%b valid=%b expected 1234/0011/0100/0",
                     alu_a, alu_b, alu_opcode, rsp_valid);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'h1245 || rsp_id !== 1'b0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp got v=%b res=%h id=%b z=%b e=%b expected 1/1245/0/0/0",
                     rsp_valid, rsp_result, rsp_id, rsp_zero, rsp_err);
        end
        step();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_opcode !== 4'b0100) begin
            errors++;
            $display("FAIL single_done got v=%b busy=%b op=%b expected 0/0/0100", rsp_valid, busy, alu_opcode);
        end
    endtask

    task automatic test_round_robin;
        logic          exp_id;
        logic [W-1:0]  exp_res;
        do_reset();
        set_req(1'b0, 4'b0101, 16'h0005, 16'h0005);
        set_req(1'b1, 4'b1010, 16'hFFFF, 16'h00FF);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_id  = k[0];
            exp_res = exp_id ? 16'hFF00 : 16'h0000;
            checks++;
            if (req_ready !== (exp_id ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rr_grant%0d got %b expected id %b", k, req_ready, exp_id);
            end
            repeat (3) step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_result !== exp_res || rsp_zero !== !exp_id) begin
                errors++;
                $display("FAIL rr_rsp%0d got v=%b id=%b res=%h z=%b expected 1/%b/%h/%b",
                         k, rsp_valid, rsp_id, rsp_result, rsp_zero, exp_id, exp_res, !exp_id);
            end
            step();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
    endtask

    task automatic test_wrap_illegal;
        logic [3:0] seen;
        do_reset();
        run_op(1'b0, 4'b0100, 16'hFFFF, 16'h0001, seen);
        checks++;
        if (rsp_result !== 16'h0000 || rsp_zero !== 1'b1 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL wrap got res=%h z=%b e=%b expected 0000/1/0", rsp_result, rsp_zero, rsp_err);
        end
        handshake();
        run_op(1'b1, 4'b0111, 16'h1234, 16'h4321, seen);
        checks++;
        if (seen !== 4'b0000) begin
            errors++; $display("FAIL illegal_aluop got %b expected 0000", seen);
        end
        checks++;
        if (rsp_err !== 1'b1 || rsp_result !== 16'h0000 || rsp_zero !== 1'b1 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL illegal_rsp got e=%b res=%h z=%b id=%b expected 1/0000/1/1", rsp_err, rsp_result, rsp_zero, rsp_id);
        end
        handshake();
    endtask

    task automatic test_backpressure;
        do_reset();
        set_req(1'b0, 4'b1011, 16'hF0F0, 16'hFF00);
        set_req(1'b1, 4'b1001, 16'h0F00, 16'h00F0);
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        #1;
        step();
        req_valid = 2'b10;
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 16'h0FFF || rsp_id !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b res=%h id=%b ready=%b busy=%b expected 1/0fff/0/00/1",
                         k, rsp_valid, rsp_result, rsp_id, req_ready, busy);
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        checks++;
        if (req_ready !== 2'b10 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_next_ready got ready=%b busy=%b expected 10/0", req_ready, busy);
        end
        step();
        req_valid = 2'b00;
        step();
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 16'h0FF0) begin
            errors++; $display("FAIL bp_req1 got v=%b id=%b res=%h expected 1/1/0ff0", rsp_valid, rsp_id, rsp_result);
        end
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_mid_reset;
        do_reset();
        set_req(1'b0, 4'b0100, 16'h0003, 16'h0004);
        set_req(1'b1, 4'b0100, 16'h0010, 16'h0020);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || alu_opcode !== 4'b0000) begin
            errors++;
            $display("FAIL midrst got busy=%b v=%b op=%b expected 0/0/0000", busy, rsp_valid, alu_opcode);
        end
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (4) step();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_norsp got v=%b busy=%b expected 0/0", rsp_valid, busy);
        end
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL midrst_prio got %b expected 01", req_ready);
        end
        req_valid = 2'b00;
        #1;
    endtask

    task automatic test_reset_not;
        logic [3:0] seen;
        do_reset();
        run_op(1'b0, 4'b0001, 16'hABCD, 16'h0001, seen);
        checks++;
        if (seen !== 4'b0000 || rsp_result !== 16'h0000 || rsp_zero !== 1'b1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL resetop got op=%b res=%h z=%b e=%b expected 0000/0000/1/0", seen, rsp_result, rsp_zero, rsp_err);
        end
        handshake();
        run_op(1'b1, 4'b1101, 16'h00FF, 16'h1234, seen);
        checks++;
        if (seen !== 4'b1101 || rsp_result !== 16'hFF00 || rsp_zero !== 1'b0 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL notop got op=%b res=%h z=%b id=%b expected 1101/ff00/0/1", seen, rsp_result, rsp_zero, rsp_id);
        end
        handshake();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_illegal();
        test_backpressure();
        test_mid_reset();
        test_reset_not();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
